// File: rtl/misc_v_pkg.sv
// Shared MISC-V core definitions: write-back select codes, datapath defaults, WB FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package misc_v_pkg;

   // Default datapath and register-file geometry
   localparam int DEF_DATA_W = 16;
   localparam int DEF_REG_AW = 3;

   // Write-back source select
   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM  = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;
   localparam logic [1:0] WB_SEL_IMM  = 2'b11;

   // Write-back stage FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_WAIT_MEM = 2'd2
   } wb_state_e;

   // True when the instruction must wait for data-memory read data
   function automatic logic is_load(input logic [1:0] sel);
      return sel == WB_SEL_MEM;
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB instruction bus, data-memory read return and register-file write port.
// Latency: n/a (signal bundle only).
// Backpressure: wb_stall from the stage holds the MEM-side producer.
interface writeback_stage_if #(
   parameter int DATA_W = misc_v_pkg::DEF_DATA_W,
   parameter int REG_AW = misc_v_pkg::DEF_REG_AW
);
   logic              mw_valid;
   logic [DATA_W-1:0] mw_pc;
   logic [DATA_W-1:0] mw_alu_result;
   logic [DATA_W-1:0] mw_imm;
   logic [REG_AW-1:0] mw_rd;
   logic              mw_reg_write;
   logic [1:0]        mw_wb_sel;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic              wb_stall;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   // Upstream / environment side
   modport master (
      output mw_valid, mw_pc, mw_alu_result, mw_imm, mw_rd, mw_reg_write, mw_wb_sel,
      output mem_rdata, mem_rvalid,
      input  wb_stall, rf_we, rf_waddr, rf_wdata
   );

   // Write-back stage side
   modport slave (
      input  mw_valid, mw_pc, mw_alu_result, mw_imm, mw_rd, mw_reg_write, mw_wb_sel,
      input  mem_rdata, mem_rvalid,
      output wb_stall, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register holding one instruction's write-back fields.
// Latency: 1 cycle from load enable to outputs.
// Backpressure: none internally; the caller gates the load enable.
module mem_wb_reg #(
   parameter int DATA_W = misc_v_pkg::DEF_DATA_W,
   parameter int REG_AW = misc_v_pkg::DEF_REG_AW
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              ld,
   input  logic [DATA_W-1:0] mw_pc,
   input  logic [DATA_W-1:0] mw_alu_result,
   input  logic [DATA_W-1:0] mw_imm,
   input  logic [REG_AW-1:0] mw_rd,
   input  logic              mw_reg_write,
   input  logic [1:0]        mw_wb_sel,
   output logic [DATA_W-1:0] wb_pc,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [DATA_W-1:0] wb_imm,
   output logic [REG_AW-1:0] wb_rd,
   output logic              wb_reg_write,
   output logic [1:0]        wb_wb_sel
);

   // Capture all fields together on load; async clear empties the register
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wb_pc         <= '0;
         wb_alu_result <= '0;
         wb_imm        <= '0;
         wb_rd         <= '0;
         wb_reg_write  <= 1'b0;
         wb_wb_sel     <= '0;
      end else if (ld) begin
         wb_pc         <= mw_pc;
         wb_alu_result <= mw_alu_result;
         wb_imm        <= mw_imm;
         wb_rd         <= mw_rd;
         wb_reg_write  <= mw_reg_write;
         wb_wb_sel     <= mw_wb_sel;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: latches MEM results, waits for load data, drives the register-file write port.
// Latency: non-load writes one cycle after capture; loads write the cycle after mem_rvalid.
// Backpressure: wb_stall (Moore, state WAIT_MEM) blocks capture until the load data returns.
module writeback_stage
   import misc_v_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int REG_AW      = DEF_REG_AW,
   parameter int LINK_OFFSET = 2,
   parameter bit ZERO_REG_RO = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   writeback_stage_if.slave   bus,
   output logic [15:0]        retired_cnt,
   output logic               err_spurious
);

   wb_state_e         state;
   logic [DATA_W-1:0] wb_pc;
   logic [DATA_W-1:0] wb_alu_result;
   logic [DATA_W-1:0] wb_imm;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_reg_write;
   logic [1:0]        wb_wb_sel;
   logic [DATA_W-1:0] load_data;
   logic              capture;
   logic              dest_ok;

   // A new instruction is accepted whenever we are not parked on a load
   assign capture = bus.mw_valid && (state != ST_WAIT_MEM);

   mem_wb_reg #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_mem_wb (
      .clk           (clk),
      .clr_n         (reset),
      .ld            (capture),
      .mw_pc         (bus.mw_pc),
      .mw_alu_result (bus.mw_alu_result),
      .mw_imm        (bus.mw_imm),
      .mw_rd         (bus.mw_rd),
      .mw_reg_write  (bus.mw_reg_write),
      .mw_wb_sel     (bus.mw_wb_sel),
      .wb_pc         (wb_pc),
      .wb_alu_result (wb_alu_result),
      .wb_imm        (wb_imm),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_wb_sel     (wb_wb_sel)
   );

   // Sequencing: pick WRITE or WAIT_MEM on capture, count retirements, flag stray load returns
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         load_data    <= '0;
         retired_cnt  <= '0;
         err_spurious <= 1'b0;
      end else begin
         // Every WRITE cycle retires one instruction, whether or not it writes a register
         if (state == ST_WRITE) begin
            retired_cnt <= retired_cnt + 16'd1;
         end
         case (state)
            ST_WAIT_MEM: begin
               if (bus.mem_rvalid) begin
                  load_data <= bus.mem_rdata;
                  state     <= ST_WRITE;
               end
            end
            default: begin
               // Nothing outstanding, so any read return here is unsolicited
               if (bus.mem_rvalid) begin
                  err_spurious <= 1'b1;
               end
               if (capture) begin
                  state <= is_load(bus.mw_wb_sel) ? ST_WAIT_MEM : ST_WRITE;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Register 0 may be hard-wired; suppress its writes when configured so
   assign dest_ok = !(ZERO_REG_RO && (wb_rd == '0));

   // Outputs depend only on state and registers, never on same-cycle inputs
   always_comb begin
      bus.rf_wdata = wb_alu_result;
      case (wb_wb_sel)
         WB_SEL_ALU:  bus.rf_wdata = wb_alu_result;
         WB_SEL_MEM:  bus.rf_wdata = load_data;
         WB_SEL_LINK: bus.rf_wdata = wb_pc + DATA_W'(LINK_OFFSET);
         WB_SEL_IMM:  bus.rf_wdata = wb_imm;
         default:     bus.rf_wdata = wb_alu_result;
      endcase
   end

   assign bus.rf_waddr = wb_rd;
   assign bus.rf_we    = (state == ST_WRITE) && wb_reg_write && dest_ok;
   assign bus.wb_stall = (state == ST_WAIT_MEM);

endmodule
